fetch_unit: RTL and testbench

//  Parametrised instruction-fetch unit; successor to the single-cycle PC/ifu block.

---
 rtl/fetch_unit_if.sv | 37 +++
 rtl/fetch_unit.sv | 214 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Purpose : Groups the instruction-memory request/response handshake between
//           the fetch unit and instruction memory.
// Signals :
//   imem_req_valid   fetch unit -> imem   request valid
//   imem_req_ready   imem -> fetch unit   request accepted this cycle
//   imem_addr        fetch unit -> imem   fetch address (the current pc)
//   imem_resp_valid  imem -> fetch unit   instruction word valid
//   imem_resp_data   imem -> fetch unit   instruction word
// Modports: master = fetch unit side, slave = instruction memory side.
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int PC_WIDTH = 32
);
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_resp_valid;
    logic [PC_WIDTH-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Purpose : Instruction-fetch unit. Holds the pc, requests the instruction at
//           pc from imem over a valid/ready handshake, holds the returned
//           word for decode and, when decode advances, moves pc to the
//           sequential, branch, jump or register-jump successor.
// Ports   :
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   imem              fetch_unit_if.master: request/response to imem
//   instr/instr_valid held instruction word and its valid flag
//   advance           decode consumes instr; control inputs sampled
//   branch, zero      taken branch when both high
//   jump, jump_reg    absolute jump, register-indirect jump
//   imm16             branch offset (sign-extended, shifted)
//   target_instr      jump target field
//   reg_target        jump_reg destination (low two bits forced to zero)
//   call, ret         return-address-stack push/pop hints
//   pc, pc_plus4      current pc and its sequential successor
// Configuration:
//   IFU_RAS_EN        when defined, adds a RAS_DEPTH-entry circular
//                     return-address stack driven by call/ret; otherwise
//                     call/ret are ignored.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int                    PC_WIDTH     = 32,
    parameter int                    IMM_WIDTH    = 16,
    parameter int                    TARGET_WIDTH = 26,
    parameter int                    BRANCH_SHIFT = 2,
    parameter logic [PC_WIDTH-1:0]   RESET_PC     = '0,
    parameter int                    RAS_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    fetch_unit_if.master            imem,
    output logic [PC_WIDTH-1:0]     instr,
    output logic                    instr_valid,
    input  logic                    advance,
    input  logic                    branch,
    input  logic                    zero,
    input  logic                    jump,
    input  logic                    jump_reg,
    input  logic [IMM_WIDTH-1:0]    imm16,
    input  logic [TARGET_WIDTH-1:0] target_instr,
    input  logic [PC_WIDTH-1:0]     reg_target,
    input  logic                    call,
    input  logic                    ret,
    output logic [PC_WIDTH-1:0]     pc,
    output logic [PC_WIDTH-1:0]     pc_plus4
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HAVE
    } state_t;

    state_t state;
    state_t state_next;

    logic take_advance;
    logic load_instr;

    logic [PC_WIDTH-1:0] branch_offset;
    logic [PC_WIDTH-1:0] branch_target;
    logic [PC_WIDTH-1:0] jump_target;
    logic [PC_WIDTH-1:0] reg_aligned;
    logic [PC_WIDTH-1:0] reg_jump_target;
    logic [PC_WIDTH-1:0] next_pc;

    // The fetch address is always the architectural pc, so it stays stable
    // for as long as a request waits for imem_req_ready.
    assign imem.imem_addr = pc;
    assign pc_plus4       = pc + PC_WIDTH'(4);

    // Target arithmetic. The branch add wraps naturally at PC_WIDTH bits; the
    // jump keeps the region bits of pc_plus4; register jumps are word-aligned
    // by masking the low two bits.
    assign branch_offset = {{(PC_WIDTH-IMM_WIDTH){imm16[IMM_WIDTH-1]}}, imm16} << BRANCH_SHIFT;
    assign branch_target = pc_plus4 + branch_offset;
    assign jump_target   = {pc_plus4[PC_WIDTH-1:TARGET_WIDTH+2], target_instr, 2'b00};
    assign reg_aligned   = reg_target & ~PC_WIDTH'(3);

    // State register: reset lands in IDLE so the first request goes out one
    // cycle after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. Response data outside WAIT and
    // advance outside HAVE are ignored simply by not being looked at there.
    always_comb begin
        state_next          = state;
        imem.imem_req_valid = 1'b0;
        take_advance        = 1'b0;
        load_instr          = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                imem.imem_req_valid = 1'b1;
                if (imem.imem_req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_resp_valid) begin
                    load_instr = 1'b1;
                    state_next = S_HAVE;
                end
            end
            S_HAVE: begin
                if (advance) begin
                    take_advance = 1'b1;
                    state_next   = S_REQ;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Successor selection: register jump beats absolute jump beats a taken
    // branch; everything else falls through to pc_plus4.
    always_comb begin
        next_pc = pc_plus4;
        if (jump_reg) begin
            next_pc = reg_jump_target;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch && zero) begin
            next_pc = branch_target;
        end
    end

    // pc and the held instruction. instr keeps its last value after advance;
    // only the valid flag drops until the next response lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            if (load_instr) begin
                instr       <= imem.imem_resp_data;
                instr_valid <= 1'b1;
            end
            if (take_advance) begin
                pc          <= next_pc;
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef IFU_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    ras_ptr;
    logic [PTR_W-1:0]    ras_top_idx;
    logic [CNT_W-1:0]    ras_count;
    logic                do_push;
    logic                do_pop;

    // ras_ptr is the next free slot; the top of stack sits just below it.
    // Because the depth is a power of two the pointer wraps on its own, and
    // a push onto a full stack lands on the oldest entry.
    assign ras_top_idx = ras_ptr - 1'b1;
    assign do_push     = take_advance && call && jump;
    assign do_pop      = take_advance && ret && jump_reg && (ras_count != '0);

    // A return with a live entry goes to the stacked address; an empty stack
    // falls back to the register target.
    assign reg_jump_target = (ret && (ras_count != '0)) ? ras_mem[ras_top_idx] : reg_aligned;

    // Stack update. Simultaneous pop and push replaces the top entry in place,
    // which leaves pointer and count untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ras_ptr   <= '0;
            ras_count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else if (do_push && do_pop) begin
            ras_mem[ras_top_idx] <= pc_plus4;
        end else if (do_push) begin
            ras_mem[ras_ptr] <= pc_plus4;
            ras_ptr          <= ras_ptr + 1'b1;
            if (ras_count != CNT_W'(RAS_DEPTH)) begin
                ras_count <= ras_count + 1'b1;
            end
        end else if (do_pop) begin
            ras_ptr   <= ras_top_idx;
            ras_count <= ras_count - 1'b1;
        end
    end
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_ras_hints;

    // Without the stack the call/ret hints have no effect.
    assign unused_ras_hints = call ^ ret;
    assign reg_jump_target  = reg_aligned;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Purpose : Directed self-checking bench for fetch_unit. The bench plays the
//           instruction memory through fetch_unit_if, queues each expected
//           instruction word and pc as stimulus is driven, and pops them when
//           the fetch unit presents its result.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        advance;
    logic        branch;
    logic        zero;
    logic        jump;
    logic        jump_reg;
    logic [15:0] imm16;
    logic [25:0] target_instr;
    logic [31:0] reg_target;
    logic        call;
    logic        ret;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_pc_q[$];

    fetch_unit_if #(.PC_WIDTH(32)) imem ();

    fetch_unit #(
        .PC_WIDTH    (32),
        .IMM_WIDTH   (16),
        .TARGET_WIDTH(26),
        .BRANCH_SHIFT(2),
        .RESET_PC    (32'h0),
        .RAS_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem.master),
        .instr       (instr),
        .instr_valid (instr_valid),
        .advance     (advance),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .jump_reg    (jump_reg),
        .imm16       (imm16),
        .target_instr(target_instr),
        .reg_target  (reg_target),
        .call        (call),
        .ret         (ret),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    // 10 ns clock; all checks happen 1 ns after the rising edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls beyond every bounded wait.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and on a miss counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Plays imem for one fetch: waits for the request, accepts it, answers
    // after lat cycles and checks the word decode sees.
    task automatic fetchWord(input logic [31:0] data, input int lat);
        logic [31:0] exp_word;
        for (int i = 0; i < 20 && imem.imem_req_valid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("req_valid", {31'b0, imem.imem_req_valid}, 32'd1);
        imem.imem_req_ready = 1'b1;
        @(posedge clk); #1;
        imem.imem_req_ready = 1'b0;
        checkOutput("req_dropped", {31'b0, imem.imem_req_valid}, 32'd0);
        for (int i = 1; i < lat; i++) begin
            @(posedge clk); #1;
        end
        exp_instr_q.push_back(data);
        imem.imem_resp_valid = 1'b1;
        imem.imem_resp_data  = data;
        @(posedge clk); #1;
        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data  = 32'h0;
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("instr_valid", {31'b0, instr_valid}, 32'd1);
        exp_word = exp_instr_q.pop_front();
        checkOutput("instr", instr, exp_word);
    endtask

    // Drives one advance with the given control inputs and checks the pc
    // that results.
    task automatic applyStimulus(input string tag,
                                 input logic br, input logic z, input logic j, input logic jr,
                                 input logic cl, input logic rt,
                                 input logic [15:0] imm, input logic [25:0] tgt,
                                 input logic [31:0] rtgt, input logic [31:0] exp_pc);
        logic [31:0] want;
        branch       = br;
        zero         = z;
        jump         = j;
        jump_reg     = jr;
        call         = cl;
        ret          = rt;
        imm16        = imm;
        target_instr = tgt;
        reg_target   = rtgt;
        advance      = 1'b1;
        exp_pc_q.push_back(exp_pc);
        @(posedge clk); #1;
        advance      = 1'b0;
        branch       = 1'b0;
        zero         = 1'b0;
        jump         = 1'b0;
        jump_reg     = 1'b0;
        call         = 1'b0;
        ret          = 1'b0;
        imm16        = 16'h0;
        target_instr = 26'h0;
        reg_target   = 32'h0;
        want = exp_pc_q.pop_front();
        checkOutput({tag, "_pc"}, pc, want);
        checkOutput({tag, "_plus4"}, pc_plus4, want + 32'd4);
        checkOutput({tag, "_ivalid"}, {31'b0, instr_valid}, 32'd0);
    endtask

`ifdef IFU_RAS_EN
    logic [31:0] ras_model[$];
`endif

    // Directed sequence.
    initial begin
        logic [31:0] cur_pc;
        logic [31:0] tgt_pc;
        logic [31:0] want;
        reset                = 1'b1;
        advance              = 1'b0;
        branch               = 1'b0;
        zero                 = 1'b0;
        jump                 = 1'b0;
        jump_reg             = 1'b0;
        call                 = 1'b0;
        ret                  = 1'b0;
        imm16                = 16'h0;
        target_instr         = 26'h0;
        reg_target           = 32'h0;
        imem.imem_req_ready  = 1'b0;
        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data  = 32'h0;

        $display("[TB] reset state");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_req_valid", {31'b0, imem.imem_req_valid}, 32'd0);
        checkOutput("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("rst_instr", instr, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("first_req_valid", {31'b0, imem.imem_req_valid}, 32'd1);
        checkOutput("first_req_addr", imem.imem_addr, 32'h0);

        $display("[TB] first fetch and sequential advance");
        fetchWord(32'hDEAD_BEEF, 1);
        applyStimulus("seq", 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'd4);
        fetchWord(32'h0000_0001, 1);
        applyStimulus("br_taken", 1, 1, 0, 0, 0, 0, 16'd16, 26'h0, 32'h0, 32'd72);

        $display("[TB] asynchronous reset mid-cycle");
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_pc", pc, 32'h0);
        checkOutput("async_rst_req_valid", {31'b0, imem.imem_req_valid}, 32'd0);
        checkOutput("async_rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("post_rst_req_valid", {31'b0, imem.imem_req_valid}, 32'd1);
        checkOutput("post_rst_req_addr", imem.imem_addr, 32'h0);

        $display("[TB] branch and jump targets");
        fetchWord(32'h0000_0002, 2);
        applyStimulus("seq2", 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'd4);
        fetchWord(32'h0000_0003, 1);
        applyStimulus("br_not_taken", 1, 0, 0, 0, 0, 0, 16'd16, 26'h0, 32'h0, 32'd8);
        fetchWord(32'h0000_0004, 1);
        applyStimulus("br_neg", 1, 1, 0, 0, 0, 0, 16'hFFFF, 26'h0, 32'h0, 32'd8);
        fetchWord(32'h0000_0005, 1);
        applyStimulus("jump", 0, 0, 1, 0, 0, 0, 16'h0, 26'd400, 32'h0, 32'd1600);
        fetchWord(32'h0000_0006, 1);
        applyStimulus("jump_over_br", 1, 1, 1, 0, 0, 0, 16'd16, 26'd400, 32'h0, 32'd1600);
        fetchWord(32'h0000_0007, 1);
        applyStimulus("jreg_wins", 1, 1, 1, 1, 0, 1, 16'd16, 26'd400, 32'h0000_1236, 32'h0000_1234);

        $display("[TB] request stall and stray response");
        imem.imem_resp_valid = 1'b1;
        imem.imem_resp_data  = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            imem.imem_resp_valid = 1'b0;
            checkOutput("stall_req_valid", {31'b0, imem.imem_req_valid}, 32'd1);
            checkOutput("stall_req_addr", imem.imem_addr, 32'h0000_1234);
        end
        checkOutput("stray_resp_ivalid", {31'b0, instr_valid}, 32'd0);
        fetchWord(32'h0000_0008, 3);

        $display("[TB] pc wrap");
        applyStimulus("jreg_top", 0, 0, 0, 1, 0, 0, 16'h0, 26'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
        fetchWord(32'h0000_0009, 1);
        applyStimulus("wrap", 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0);

`ifdef IFU_RAS_EN
        $display("[TB] return-address stack");
        fetchWord(32'h0000_000A, 1);
        applyStimulus("to_100", 0, 0, 0, 1, 0, 0, 16'h0, 26'h0, 32'h0000_0100, 32'h0000_0100);
        fetchWord(32'h0000_000B, 1);
        applyStimulus("call_400", 0, 0, 1, 0, 1, 0, 16'h0, 26'h100, 32'h0, 32'h0000_0400);
        fetchWord(32'h0000_000C, 1);
        applyStimulus("ret_104", 0, 0, 0, 1, 0, 1, 16'h0, 26'h0, 32'h0, 32'h0000_0104);
        cur_pc = 32'h0000_0104;
        for (int i = 0; i < 5; i++) begin
            tgt_pc = 32'h1000 * (i + 1);
            ras_model.push_back(cur_pc + 32'd4);
            if (ras_model.size() > 4) begin
                void'(ras_model.pop_front());
            end
            fetchWord(32'h0000_0100 + i, 1);
            applyStimulus("ras_call", 0, 0, 1, 0, 1, 0, 16'h0, tgt_pc[27:2], 32'h0, tgt_pc);
            cur_pc = tgt_pc;
        end
        for (int i = 0; i < 5; i++) begin
            want = (ras_model.size() > 0) ? ras_model.pop_back() : 32'h0000_8888;
            fetchWord(32'h0000_0200 + i, 1);
            applyStimulus("ras_ret", 0, 0, 0, 1, 0, 1, 16'h0, 26'h0, 32'h0000_8888, want);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
